uart_baud_generator: RTL and testbench
======================================

// Module: uart_baud_generator
// PURPOSE
//  Derives the UART 16x oversampling timebase from the system clock for a runtime-selected baud rate.
//  Output tick is a 4-bit phase counter: it advances once per 1/16 bit period and wraps 15->0 once per bit.
//  Sits between the register/config interface (Baud_Rate) and the UART TX/RX engines, which use tick phase.
// PARAMETERS
//  CLK_FREQ_HZ  100_000_000  system clock frequency in Hz (bench clock period 10 ns)
//  DIV_W        16           prescaler counter width; must hold the largest divisor (1200 baud)
// PORTS
//  clk        in   1   system clock, all logic on rising edge
//  rst        in   1   synchronous, active-high reset
//  Baud_Rate  in   17  requested baud rate in bit/s (binary integer)
//  tick       out  4   16x oversample phase, 0..15
//  rate_err   out  1   unsupported-rate flag (only when UART_BAUD_RATE_ERR_EN defined)
// BEHAVIOUR
//  - One clock; reset is synchronous and active-high.
//  - Supported rates: 1200, 2400, 4800, 9600, 14400, 19200, 38400, 57600, 115200.
//  - Divisor DIV(B) = (CLK_FREQ_HZ + 8*B) / (16*B), integer, round-to-nearest; all are elaboration-time localparams.
//    No runtime divider.
//  - DIV at 100 MHz: 1200=5208, 2400=2604, 4800=1302, 9600=651, 14400=434, 19200=326,
//    38400=163, 57600=109, 115200=54.
//  - Any other Baud_Rate value (incl. 0) selects the 9600 divisor.
//  - Divisor select is combinational from Baud_Rate through a case decode, then registered (div_q) each cycle.
//  - Prescaler div_cnt counts 0..div_q-1. When div_cnt==div_q-1: div_cnt<=0, tick<=tick+1 (mod 16, 15 wraps to 0).
//    Otherwise div_cnt<=div_cnt+1.
//  - Reset: div_cnt=0, tick=0, div_q=divisor of current Baud_Rate, rate_err=0. Reset has priority over all else.
//  - Rate change: a registered copy of Baud_Rate is compared each cycle.
//    On mismatch, the next edge loads the new div_q, clears div_cnt and tick to 0, and updates the copy.
//    No tick advance occurs on that edge.
//  - Latency: first tick 0->1 exactly DIV clocks after reset deassert.
//    tick==15 first reached 15*DIV clocks after reset deassert.
//  - Full wrap period (tick back to 0) = 16*DIV clocks.
//  - Rate change on the same edge as a prescaler terminal count: the restart wins; tick goes to 0.
//  - tick is a plain register: glitch-free, changes only on clk rising edge.
// CONFIGURATION
//  UART_BAUD_RATE_ERR_EN defined:
//  - Adds output rate_err, registered.
//  - rate_err=1 while the latched Baud_Rate is not in the supported list; cleared on reset or a supported value.
//  - Fallback to 9600 still applies.
//  UART_BAUD_RATE_ERR_EN undefined: port and logic absent; behaviour otherwise identical.
// TESTING
//  - Reset held 3 cycles, Baud_Rate=1200 -> tick=0 throughout reset.
//    tick=1 at 5208 clocks after release; tick=15 at 78120 clocks (781.2 us).
//  - Baud_Rate=115200 -> tick increments every 54 clocks; wraps 15->0 every 864 clocks.
//    Check 3 full wraps.
//  - Baud_Rate 9600->57600 mid-count (tick=7) -> tick=0 next cycle; next increment after 109 clocks.
//  - Baud_Rate=12345 (unsupported) -> period 651 clocks, same as 9600.
//    With UART_BAUD_RATE_ERR_EN, rate_err=1; back to 2400 -> rate_err=0, period 2604.
//  - rst asserted at tick=9, div_cnt mid-count -> next edge tick=0, div_cnt=0; count restarts cleanly after release.
//  - Sweep all 9 supported rates -> measured clocks between tick increments equal the DIV table exactly.

Source files
------------

// File: rtl/uart_baud_generator.sv
// uart_baud_generator: 16x oversampling phase counter for a runtime-selected UART baud rate.
// Define UART_BAUD_RATE_ERR_EN to add the registered rate_err flag for unsupported rates.
module uart_baud_generator #(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int DIV_W       = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [16:0] Baud_Rate,
    output logic [3:0]  tick
`ifdef UART_BAUD_RATE_ERR_EN
    ,
    output logic        rate_err
`endif
);
    function automatic logic [DIV_W-1:0] div_of(input int b);
        return DIV_W'((CLK_FREQ_HZ + 8 * b) / (16 * b));
    endfunction

    localparam logic [DIV_W-1:0] DIV_1200   = div_of(1200);
    localparam logic [DIV_W-1:0] DIV_2400   = div_of(2400);
    localparam logic [DIV_W-1:0] DIV_4800   = div_of(4800);
    localparam logic [DIV_W-1:0] DIV_9600   = div_of(9600);
    localparam logic [DIV_W-1:0] DIV_14400  = div_of(14400);
    localparam logic [DIV_W-1:0] DIV_19200  = div_of(19200);
    localparam logic [DIV_W-1:0] DIV_38400  = div_of(38400);
    localparam logic [DIV_W-1:0] DIV_57600  = div_of(57600);
    localparam logic [DIV_W-1:0] DIV_115200 = div_of(115200);

    logic [16:0]      baud_q;
    logic [DIV_W-1:0] div_d, div_q, cnt_d, cnt_q;
    logic [3:0]       tick_d, tick_q;
    logic             restart, term;

    // Unsupported rates fall back to the 9600 divisor.
    always_comb begin
        div_d = DIV_9600;
        case (Baud_Rate)
            17'd1200:   div_d = DIV_1200;
            17'd2400:   div_d = DIV_2400;
            17'd4800:   div_d = DIV_4800;
            17'd14400:  div_d = DIV_14400;
            17'd19200:  div_d = DIV_19200;
            17'd38400:  div_d = DIV_38400;
            17'd57600:  div_d = DIV_57600;
            17'd115200: div_d = DIV_115200;
            default:    div_d = DIV_9600;
        endcase
    end

    assign restart = Baud_Rate != baud_q;
    assign term    = cnt_q == div_q - DIV_W'(1);

    // A rate change restarts the phase even on a terminal-count edge.
    always_comb begin
        cnt_d  = (restart || term) ? '0 : cnt_q + DIV_W'(1);
        tick_d = restart ? 4'd0 : term ? tick_q + 4'd1 : tick_q;
    end

    always_ff @(posedge clk) begin
        baud_q <= Baud_Rate;
        div_q  <= div_d;
        if (rst) begin
            cnt_q  <= '0;
            tick_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

`ifdef UART_BAUD_RATE_ERR_EN
    logic sup_d, err_q;

    assign sup_d = Baud_Rate inside {17'd1200, 17'd2400, 17'd4800, 17'd9600, 17'd14400,
                                     17'd19200, 17'd38400, 17'd57600, 17'd115200};

    always_ff @(posedge clk) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= ~sup_d;
    end

    assign rate_err = err_q;
`endif
endmodule

// File: tb/tb_uart_baud_generator.sv
// tb_uart_baud_generator: scoreboard bench measuring clocks between tick phase advances.
module tb_uart_baud_generator;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [16:0] baud = 17'd1200;
    logic [3:0]  tick;
`ifdef UART_BAUD_RATE_ERR_EN
    logic        rate_err;
`endif

    uart_baud_generator dut (
        .clk      (clk),
        .rst      (rst),
        .Baud_Rate(baud),
        .tick     (tick)
`ifdef UART_BAUD_RATE_ERR_EN
        ,
        .rate_err (rate_err)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int tick;
        int gap;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   exp_tick = 0;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic push(input int n, input int div);
        for (int i = 0; i < n; i++) begin
            exp_tick = (exp_tick + 1) % 16;
            exp_q.push_back('{tick: exp_tick, gap: div});
        end
    endtask

    task automatic wait_change(output int gap, output int t);
        logic [3:0] t0;
        t0  = tick;
        gap = 0;
        while (tick == t0 && gap < 6000) begin
            @(negedge clk);
            gap++;
        end
        t = int'(tick);
    endtask

    task automatic drain(input string tag, output int span);
        exp_t e;
        int   gap, t;
        span = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            wait_change(gap, t);
            span += gap;
            chk({tag, "_gap"}, gap, e.gap);
            chk({tag, "_tick"}, t, e.tick);
        end
    endtask

    task automatic set_baud(input int b);
        @(negedge clk);
        baud = 17'(b);
        @(negedge clk);
        chk("restart_tick", int'(tick), 0);
        exp_tick = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    int rates[9] = '{1200, 2400, 4800, 9600, 14400, 19200, 38400, 57600, 115200};
    int divs[9]  = '{5208, 2604, 1302, 651, 434, 326, 163, 109, 54};

    initial begin
        int span;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("reset_tick", int'(tick), 0);
        end
        rst = 1'b0;
        push(2, 5208);
        drain("b1200", span);
        chk("b1200_span", span, 2 * 5208);

        set_baud(115200);
        push(15, 54);
        drain("b115200_to15", span);
        chk("first_tick15", span, 15 * 54);
        for (int w = 0; w < 3; w++) begin
            push(16, 54);
            drain("b115200_wrap", span);
            chk("wrap_period", span, 864);
        end

        set_baud(9600);
        push(7, 651);
        drain("b9600", span);
        idle(300);
        set_baud(57600);
        push(2, 109);
        drain("b57600", span);

        idle(107);
        set_baud(38400);
        push(1, 163);
        drain("collide", span);

        set_baud(12345);
`ifdef UART_BAUD_RATE_ERR_EN
        chk("rate_err_set", int'(rate_err), 1);
`endif
        push(2, 651);
        drain("unsupported", span);
        set_baud(2400);
`ifdef UART_BAUD_RATE_ERR_EN
        chk("rate_err_clr", int'(rate_err), 0);
`endif
        push(2, 2604);
        drain("b2400", span);

        set_baud(9600);
        push(9, 651);
        drain("pre_rst", span);
        idle(200);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_tick", int'(tick), 0);
        rst = 1'b0;
        exp_tick = 0;
        push(2, 651);
        drain("post_rst", span);

        for (int r = 0; r < 9; r++) begin
            set_baud(rates[r]);
            push(2, divs[r]);
            drain($sformatf("sweep%0d", rates[r]), span);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
